ec_dlog_search: RTL and testbench
=================================

Name: ec_dlog_search

Overview:
- Sequential elliptic-curve discrete-log solver over y^2 = x^3 + 4x + b (mod m), m prime.
- Given base point P and target Q, finds the smallest k in 0..kmax with kP = Q by repeated point addition R <- R + P.
- Inverse of the existing scalar-multiply path: recovers the scalar from the product point. Used for key-recovery checks on small test curves.
- Curve coefficient a = 4 is fixed. The point at infinity O is encoded as (0,0).

Parameters:
- W, 16, coordinate/modulus width. All coordinates unsigned, < m. Internal products are 2W bits.
- KW, 16, width of the scalar counter, kmax and k.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only when busy=0
- m  in  W  prime modulus, 3 <= m < 2^W; sampled at start
- curve_b  in  W  curve coefficient b; sampled at start; used only with the optional feature
- px, py  in  W each  base point P; sampled at start
- qx, qy  in  W each  target point Q; sampled at start
- kmax  in  KW  search limit; sampled at start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of search
- found  out  1  valid with done; 1 = match
- k  out  KW  valid with done; matching scalar, or last k tried
- err  out  1  valid with done; input point not on curve (optional feature only)

Behaviour:
- Reset: busy=0, done=0, found=0, k=0, err=0. FSM goes to IDLE. Reset mid-search aborts with no done pulse.
- Output hold: found, k and err hold their values until the next start.
- FSM states: IDLE, CHECK, ADD_SETUP, INV, ADD_FIN, COMPARE, FIN.
- IDLE: on start, latch inputs, set R=O and kc=0, go to CHECK.
- CHECK: if Q==O, finish with found=1, k=0. Otherwise go to ADD_SETUP.
- ADD_SETUP: compute R + P using the following cases.
  - R==O gives P; go directly to COMPARE.
  - Rx==Px and (Ry+Py) mod m == 0 gives O; go to COMPARE.
  - R==P (doubling): num = (3*Rx*Rx + 4) mod m, den = (2*Ry) mod m.
  - Otherwise: num = (Py - Ry) mod m, den = (Px - Rx) mod m.
  - For both num/den cases, go to INV.
- INV: den^(m-2) mod m by MSB-first square-and-multiply over W exponent bits.
  - One modular multiply per cycle, (a*b) % m with a 2W-bit product.
  - Each exponent bit costs 2 cycles (square, then conditional multiply).
  - INV takes exactly 2W cycles.
- ADD_FIN: lam = num*inv mod m, x3 = (lam^2 - Rx - Px) mod m, y3 = (lam*(Rx - x3) - Ry) mod m. At most 3 cycles.
- Subtraction rule: all subtractions add m before reducing, so results are never negative.
- COMPARE: R <- result, kc <- kc+1.
  - If R==Q: finish with found=1, k=kc.
  - Else if R==O (order reached) or kc==kmax: finish with found=0, k=kc.
  - Else go to ADD_SETUP.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency per addition: at most 1 + 2W + 3 + 1 cycles, i.e. 37 for W=16.
- start while busy=1 is ignored.
- kmax=0: only the Q==O check runs. Result is found=0, k=0 unless Q==O.

Optional Feature:
- Macro: EC_DLOG_ONCURVE_CHECK_EN.
- Defined:
  - CHECK first verifies y^2 == x^3 + 4x + curve_b (mod m) for P (must be non-O) and for Q (if non-O).
  - Evaluation is sequential, one modular multiply per cycle, at most 8 extra cycles.
  - On failure: done pulses with err=1, found=0, k=0.
- Undefined: err is tied to 0, curve_b is unused, and CHECK goes straight to the Q==O test.

Test Plan:
- Curve for all cases: m=13, b=4, P=(0,2). Multiples: 2P=(1,10), 3P=(11,1).
- Q=(11,1), kmax=10 -> done, found=1, k=3, err=0; busy high for the whole search.
- Q=(1,10), kmax=10 -> found=1, k=2. Exercises the doubling path with lam=1.
- Q=(0,0) -> done within 3 cycles of start, found=1, k=0.
- Q=(0,11)=-P, kmax=3 -> found=0, k=3. A second start pulsed while busy is ignored.
- Reset asserted mid-INV -> no done pulse, busy=0. A new start with Q=(11,1) -> found=1, k=3.
- With EC_DLOG_ONCURVE_CHECK_EN defined, Q=(1,1) -> done, err=1, found=0 (1 != 9 mod 13). Without the macro: search runs to kmax=10, found=0, err=0.

Source files
------------

// File: rtl/ec_dlog_search.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ec_dlog_search: finds the smallest k in 0..kmax with kP = Q on the curve
// y^2 = x^3 + 4x + b (mod m), by repeated R <- R + P. Point at infinity is (0,0).
// Optional input on-curve check: define EC_DLOG_ONCURVE_CHECK_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module ec_dlog_search #(
  parameter int W  = 16,
  parameter int KW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  m,
  input  logic [W-1:0]  curve_b,
  input  logic [W-1:0]  px,
  input  logic [W-1:0]  py,
  input  logic [W-1:0]  qx,
  input  logic [W-1:0]  qy,
  input  logic [KW-1:0] kmax,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [KW-1:0] k,
  output logic          err
);
  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] BIT_TOP = BW'(W - 1);

  typedef enum logic [2:0] {IDLE, CHECK, ADD_SETUP, INV, ADD_FIN, COMPARE, FIN} state_t;
  state_t state, state_nx;

  logic [W-1:0]  mr, pxr, pyr, qxr, qyr, rx, ry;
  logic [W-1:0]  num, den, acc, lam, res_x, res_y, expo, dx;
  logic [KW-1:0] kmr, kc, kc_nx;
  logic [BW-1:0] bitn;
  logic          phase;
  logic [1:0]    fs;
  logic [W-1:0]  ma, mb, mp;
  logic [2*W-1:0] prod;
  logic r_is_o, r_eq_p, r_neg_p, q_is_o, res_is_o, res_eq_q;
  logic chk_go, chk_fail;

  function automatic logic [W+1:0] ex(input logic [W-1:0] v);
    return {2'b00, v};
  endfunction

  // Operands are at most three residues wide, so one remainder suffices.
  function automatic logic [W-1:0] modm(input logic [W+1:0] v, input logic [W-1:0] md);
    return W'(v % ex(md));
  endfunction

  // Single shared modular multiplier; operands are muxed by state below.
  assign prod = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
  assign mp   = W'(prod % {{W{1'b0}}, mr});

  assign expo     = mr - W'(2);
  assign r_is_o   = (rx == '0) && (ry == '0);
  assign r_eq_p   = (rx == pxr) && (ry == pyr);
  assign r_neg_p  = (rx == pxr) && (modm(ex(ry) + ex(pyr), mr) == '0);
  assign q_is_o   = (qxr == '0) && (qyr == '0);
  assign res_is_o = (res_x == '0) && (res_y == '0);
  assign res_eq_q = (res_x == qxr) && (res_y == qyr);
  assign kc_nx    = kc + 1'b1;
  assign dx       = modm(ex(rx) + ex(mr) - ex(res_x), mr);

`ifdef EC_DLOG_ONCURVE_CHECK_EN
  logic [W-1:0] br, t1, t2, cx, cy, rhs;
  logic [2:0]   chk;
  logic         on_curve, chk_last, err_r;

  // Steps 0..2 test P, steps 3..5 test Q: y^2, x^2, then x^3 and compare.
  assign cx       = (chk < 3'd3) ? pxr : qxr;
  assign cy       = (chk < 3'd3) ? pyr : qyr;
  assign rhs      = modm(ex(mp) + ex(modm(ex(cx) << 2, mr)) + ex(modm(ex(br), mr)), mr);
  assign on_curve = (t1 == rhs);
  assign chk_last = (chk == 3'd2) || (chk == 3'd5);
  assign chk_fail = ((chk == 3'd0) && (pxr == '0) && (pyr == '0)) || (chk_last && !on_curve);
  assign chk_go   = chk_last && on_curve && ((chk == 3'd5) || q_is_o);
  assign err      = err_r;
`else
  logic unused_b;
  assign unused_b = ^curve_b;
  assign chk_fail = 1'b0;
  assign chk_go   = 1'b1;
  assign err      = 1'b0;
`endif

  always_comb begin
    ma = acc;
    mb = acc;
    case (state)
`ifdef EC_DLOG_ONCURVE_CHECK_EN
      CHECK: begin
        case (chk)
          3'd0, 3'd3: begin ma = cy; mb = cy; end
          3'd1, 3'd4: begin ma = cx; mb = cx; end
          default:    begin ma = t2; mb = cx; end
        endcase
      end
`endif
      ADD_SETUP: begin ma = rx; mb = rx; end
      INV:       if (phase) mb = den;
      ADD_FIN: begin
        case (fs)
          2'd0:    begin ma = num; mb = acc; end
          2'd1:    begin ma = lam; mb = lam; end
          default: begin ma = lam; mb = dx; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE) && (state != FIN);
    done     = (state == FIN);
    case (state)
      IDLE:      if (start) state_nx = CHECK;
      CHECK: begin
        if (chk_fail)    state_nx = FIN;
        else if (chk_go) state_nx = (q_is_o || kmr == '0) ? FIN : ADD_SETUP;
      end
      ADD_SETUP: state_nx = (r_is_o || r_neg_p) ? COMPARE : INV;
      INV:       if (phase && bitn == '0) state_nx = ADD_FIN;
      ADD_FIN:   if (fs == 2'd2) state_nx = COMPARE;
      COMPARE:   state_nx = (res_eq_q || res_is_o || kc_nx == kmr) ? FIN : ADD_SETUP;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      found <= 1'b0;
      k     <= '0;
      kc    <= '0;
      rx    <= '0;
      ry    <= '0;
`ifdef EC_DLOG_ONCURVE_CHECK_EN
      err_r <= 1'b0;
      chk   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          mr  <= m;   pxr <= px;  pyr <= py;
          qxr <= qx;  qyr <= qy;  kmr <= kmax;
          rx  <= '0;  ry  <= '0;  kc  <= '0;
`ifdef EC_DLOG_ONCURVE_CHECK_EN
          br    <= curve_b;
          chk   <= '0;
          err_r <= 1'b0;
`endif
        end
        CHECK: begin
`ifdef EC_DLOG_ONCURVE_CHECK_EN
          chk <= chk + 3'd1;
          case (chk)
            3'd0, 3'd3: t1 <= mp;
            3'd1, 3'd4: t2 <= mp;
            default: ;
          endcase
          if (chk_fail) begin
            err_r <= 1'b1;
            found <= 1'b0;
            k     <= '0;
          end
`endif
          if (!chk_fail && chk_go && (q_is_o || kmr == '0)) begin
            found <= q_is_o;
            k     <= '0;
          end
        end
        ADD_SETUP: begin
          acc   <= W'(1);
          bitn  <= BIT_TOP;
          phase <= 1'b0;
          fs    <= 2'd0;
          if (r_is_o) begin
            res_x <= pxr;
            res_y <= pyr;
          end else if (r_neg_p) begin
            res_x <= '0;
            res_y <= '0;
          end else if (r_eq_p) begin
            num <= modm((ex(mp) << 1) + ex(mp) + ex(W'(4)), mr);
            den <= modm(ex(ry) << 1, mr);
          end else begin
            num <= modm(ex(pyr) + ex(mr) - ex(ry), mr);
            den <= modm(ex(pxr) + ex(mr) - ex(rx), mr);
          end
        end
        INV: begin
          // Fermat inverse: square, then multiply only where the exponent bit is set.
          if (!phase || expo[bitn]) acc <= mp;
          phase <= ~phase;
          if (phase) bitn <= bitn - 1'b1;
        end
        ADD_FIN: begin
          fs <= fs + 2'd1;
          case (fs)
            2'd0:    lam   <= mp;
            2'd1:    res_x <= modm(ex(mp) + ex(mr) + ex(mr) - ex(rx) - ex(pxr), mr);
            default: res_y <= modm(ex(mp) + ex(mr) - ex(ry), mr);
          endcase
        end
        COMPARE: begin
          rx <= res_x;
          ry <= res_y;
          kc <= kc_nx;
          if (res_eq_q || res_is_o || kc_nx == kmr) begin
            found <= res_eq_q;
            k     <= kc_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ec_dlog_search.sv
`default_nettype none
// tb_ec_dlog_search: directed searches on m=13, b=4, P=(0,2); expected results
// are queued at each start and checked when done pulses.
module tb_ec_dlog_search;
  localparam int W  = 16;
  localparam int KW = 16;
`ifdef EC_DLOG_ONCURVE_CHECK_EN
  localparam int LAT_K3 = 1 + 3 * 37 + 1 + 8;
`else
  localparam int LAT_K3 = 1 + 3 * 37 + 1;
`endif

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  m, curve_b, px, py, qx, qy;
  logic [KW-1:0] kmax;
  logic          busy, done, found, err;
  logic [KW-1:0] k;

  typedef struct packed {
    logic          f;
    logic [KW-1:0] kk;
    logic          e;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc;
  int   busy_drop;
  int   extra;

  ec_dlog_search #(.W(W), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .curve_b(curve_b),
    .px(px), .py(py), .qx(qx), .qy(qy), .kmax(kmax),
    .busy(busy), .done(done), .found(found), .k(k), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic [KW-1:0] lim);
    qx    = x;
    qy    = y;
    kmax  = lim;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic [KW-1:0] lim,
                        input logic f, input logic [KW-1:0] kk, input logic e);
    res_t r;
    r.f  = f;
    r.kk = kk;
    r.e  = e;
    sb.push_back(r);
    pulse_start(x, y, lim);
  endtask

  task automatic wait_done(input string tag, input int bound);
    res_t r;
    cyc       = 0;
    busy_drop = 0;
    while (!done && cyc < bound) begin
      if (!busy) busy_drop++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " busy held"}, 32'(busy_drop), 32'd0);
    check({tag, " busy low at done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      r = sb.pop_front();
      check({tag, " found"}, 32'(found), 32'(r.f));
      check({tag, " k"},     32'(k),     32'(r.kk));
      check({tag, " err"},   32'(err),   32'(r.e));
    end
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    m       = 16'd13;
    curve_b = 16'd4;
    px      = 16'd0;
    py      = 16'd2;
    qx      = '0;
    qy      = '0;
    kmax    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",  32'(busy),  32'd0);
    check("reset done",  32'(done),  32'd0);
    check("reset found", 32'(found), 32'd0);
    check("reset k",     32'(k),     32'd0);
    check("reset err",   32'(err),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Q = 3P
    launch(16'd11, 16'd1, 16'd10, 1'b1, 16'd3, 1'b0);
    wait_done("q3p", 2000);
    check("q3p latency ok", 32'(cyc <= LAT_K3), 32'd1);

    // Q = 2P, doubling path with lam = 1
    launch(16'd1, 16'd10, 16'd10, 1'b1, 16'd2, 1'b0);
    wait_done("q2p", 2000);

    // Q = O resolves in CHECK
    launch(16'd0, 16'd0, 16'd10, 1'b1, 16'd0, 1'b0);
    wait_done("qinf", 2000);
    check("qinf latency ok", 32'(cyc <= 3), 32'd1);

    // Q = -P with kmax = 3; a start mid-search must be ignored
    launch(16'd0, 16'd11, 16'd3, 1'b0, 16'd3, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    pulse_start(16'd11, 16'd1, 16'd10);
    qx = 16'd0; qy = 16'd11; kmax = 16'd3;
    wait_done("qnegp", 2000);
    extra = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("no second run", 32'(extra), 32'd0);

    // Reset while inverting: no done pulse, then a clean search
    pulse_start(16'd11, 16'd1, 16'd10);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy",  32'(busy),  32'd0);
    check("abort done",  32'(done),  32'd0);
    check("abort found", 32'(found), 32'd0);
    check("abort k",     32'(k),     32'd0);
    rst = 1'b0;
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("abort no done", 32'(extra), 32'd0);
    launch(16'd11, 16'd1, 16'd10, 1'b1, 16'd3, 1'b0);
    wait_done("after abort", 2000);

    // kmax = 0 with Q non-O
    launch(16'd11, 16'd1, 16'd0, 1'b0, 16'd0, 1'b0);
    wait_done("kmax0", 2000);

    // Further multiples: 4P = (12,5), 8P = (6,7)
    launch(16'd12, 16'd5, 16'd10, 1'b1, 16'd4, 1'b0);
    wait_done("q4p", 4000);
    launch(16'd6, 16'd7, 16'd10, 1'b1, 16'd8, 1'b0);
    wait_done("q8p", 4000);

    // Q = (1,1) is off the curve; P has order 15
`ifdef EC_DLOG_ONCURVE_CHECK_EN
    launch(16'd1, 16'd1, 16'd10, 1'b0, 16'd0, 1'b1);
    wait_done("offcurve", 4000);
    launch(16'd1, 16'd1, 16'd20, 1'b0, 16'd0, 1'b1);
    wait_done("order", 4000);
`else
    launch(16'd1, 16'd1, 16'd10, 1'b0, 16'd10, 1'b0);
    wait_done("offcurve", 4000);
    launch(16'd1, 16'd1, 16'd20, 1'b0, 16'd15, 1'b0);
    wait_done("order", 4000);
`endif

    // Results hold while idle
    repeat (5) @(posedge clk);
    #1;
    check("hold found", 32'(found), 32'd0);
`ifdef EC_DLOG_ONCURVE_CHECK_EN
    check("hold k", 32'(k), 32'd0);
`else
    check("hold k", 32'(k), 32'd15);
`endif
    check("idle busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
